// File: rtl/bpsk_pkg.sv
// Shared BPSK constants, accumulator width derivation and demodulator FSM states.
// Used by the modulator, the demodulator and the testbench.
// Pure declarations; no logic, no latency.
package bpsk_pkg;

  localparam int DEF_SAMPLE_NUMBER = 256;
  localparam int DEF_SAMPLE_WIDTH  = 12;
  localparam int DEF_DATA_WIDTH    = 12;

  // Sum of SAMPLE_NUMBER products of two SAMPLE_WIDTH-bit values cannot overflow this width.
  function automatic int acc_width(input int sample_width, input int sample_number);
    return 2 * sample_width + $clog2(sample_number);
  endfunction

  localparam int DEF_ACC_WIDTH = acc_width(DEF_SAMPLE_WIDTH, DEF_SAMPLE_NUMBER);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

endpackage

// File: rtl/bpsk_correlator.sv
// Registered multiply followed by a first/last-tagged accumulate over one symbol period.
// Latency: o_done/o_sum are valid combinationally one qualified edge after the last sample.
// No backpressure: everything (including the tags) advances only while i_en is high.
module bpsk_correlator
  import bpsk_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic                          i_take,
  input  logic                          i_first,
  input  logic                          i_last,
  input  logic signed [SAMPLE_WIDTH-1:0] i_signal,
  input  logic signed [SAMPLE_WIDTH-1:0] i_sine,
  output logic signed [ACC_WIDTH-1:0]   o_sum,
  output logic                          o_done
);

  localparam int PROD_W = 2 * SAMPLE_WIDTH;

  logic signed [PROD_W-1:0]    r_prod;
  logic                        r_vld;
  logic                        r_first;
  logic                        r_last;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_sum;

  // Stage 1: register the product together with its framing tags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prod  <= '0;
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_en) begin
      r_prod  <= i_signal * i_sine;
      r_vld   <= i_take;
      r_first <= i_first;
      r_last  <= i_last;
    end
  end

  assign w_prod_ext = {{(ACC_WIDTH - PROD_W){r_prod[PROD_W-1]}}, r_prod};
  // A first-tagged product restarts the sum, dropping any partial period.
  assign w_sum      = r_first ? w_prod_ext : (r_acc + w_prod_ext);

  // Stage 2: accumulate the registered product.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_en && r_vld) begin
      r_acc <= w_sum;
    end
  end

  assign o_sum  = w_sum;
  assign o_done = i_en && r_vld && r_last;

endmodule

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK demodulator: correlate per carrier period, slice one bit, rebuild LSB-first words.
// Latency: bit/word appear one qualified edge after the edge that takes the last sample of a period.
// No backpressure: en low is a pure pause; outputs are single-cycle pulses.
module bpsk_demodulator
  import bpsk_pkg::*;
#(
  parameter int SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
  parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic signed [SAMPLE_WIDTH-1:0]   signal_in,
  input  logic signed [SAMPLE_WIDTH-1:0]   sine_in,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_in,
  output logic                             bit_out,
  output logic                             bit_valid,
  output logic [DATA_WIDTH-1:0]            data,
  output logic                             data_valid,
  output logic                             locked
);

  localparam int CNT_W     = $clog2(SAMPLE_NUMBER);
  localparam int BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int ACC_WIDTH = acc_width(SAMPLE_WIDTH, SAMPLE_NUMBER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_NUMBER - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  state_t                      r_state;
  logic                        r_bit_out;
  logic                        r_bit_valid;
  logic [DATA_WIDTH-1:0]       r_data;
  logic                        r_data_valid;
  logic [DATA_WIDTH-1:0]       r_shift;
  logic [BIT_W-1:0]            r_bit_cnt;

  logic                        w_first;
  logic                        w_last;
  logic                        w_take;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_done;
  logic                        w_bit;
  logic [DATA_WIDTH-1:0]       w_word;

  assign w_first = (cnt_in == '0);
  assign w_last  = (cnt_in == CNT_LAST);
  // While searching, only the period-start sample is let through; it is the first sample of the first symbol.
  assign w_take  = (r_state == TRACK) || w_first;

  bpsk_correlator #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_correlator (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_take   (w_take),
    .i_first  (w_first),
    .i_last   (w_last),
    .i_signal (signal_in),
    .i_sine   (sine_in),
    .o_sum    (w_sum),
    .o_done   (w_done)
  );

  // Exact zero correlation slices to 1.
  assign w_bit = (w_sum >= 0);

  // Current partial word with the bit being sliced dropped into its LSB-first slot.
  always_comb begin
    w_word            = r_shift;
    w_word[r_bit_cnt] = w_bit;
  end

  // Framing FSM: lock on the first qualified period-start sample, then track until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEARCH;
    end else if (en && (r_state == SEARCH) && w_first) begin
      r_state <= TRACK;
    end
  end

  // Slicer, bit counter and word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
    end else begin
      r_bit_valid  <= w_done;
      r_data_valid <= 1'b0;
      if (w_done) begin
        r_bit_out <= w_bit;
        r_shift   <= w_word;
        if (r_bit_cnt == BIT_LAST) begin
          r_bit_cnt    <= '0;
          r_data       <= w_word;
          r_data_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  assign bit_out    = r_bit_out;
  assign bit_valid  = r_bit_valid;
  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign locked     = (r_state == TRACK);

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Testbench for bpsk_demodulator: directed scenarios plus randomized periods,
// every cycle compared against a per-period correlation model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_bpsk_demodulator;
  import bpsk_pkg::*;

  localparam int N  = DEF_SAMPLE_NUMBER;
  localparam int DW = DEF_DATA_WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [11:0]       signal_in;
  logic [11:0]       sine_in;
  logic [7:0]        cnt_in;
  logic              bit_out;
  logic              bit_valid;
  logic [DW-1:0]     data;
  logic              data_valid;
  logic              locked;

  bpsk_demodulator dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .signal_in  (signal_in),
    .sine_in    (sine_in),
    .cnt_in     (cnt_in),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .data       (data),
    .data_valid (data_valid),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int rom [N];

  // reference model state
  bit          m_locked;
  longint      m_sum;
  bit          m_pend;
  bit          m_pend_bit;
  int          m_idx;
  logic [DW-1:0] m_word;
  logic [DW-1:0] m_data;

  // observations
  int          bv_cnt = 0;
  int          dv_cnt = 0;
  logic [DW-1:0] last_data = '0;
  bit          obs_bits[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  task automatic model_reset();
    m_locked   = 1'b0;
    m_sum      = 0;
    m_pend     = 1'b0;
    m_pend_bit = 1'b0;
    m_idx      = 0;
    m_word     = '0;
    m_data     = '0;
  endtask

  // One clock with the given inputs, then compare all outputs with the model.
  task automatic step(input bit e, input int sig, input int sn, input int cnt);
    bit exp_bv;
    bit exp_dv;
    bit exp_bit;
    longint prod;
    en        = e;
    signal_in = sig[11:0];
    sine_in   = sn[11:0];
    cnt_in    = cnt[7:0];
    @(posedge clk);
    #1;
    exp_bv  = e && m_pend;
    exp_dv  = 1'b0;
    exp_bit = 1'b0;
    if (exp_bv) begin
      m_pend        = 1'b0;
      exp_bit       = m_pend_bit;
      m_word[m_idx] = m_pend_bit;
      if (m_idx == DW - 1) begin
        exp_dv = 1'b1;
        m_data = m_word;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end
    if (e) begin
      if (!m_locked && cnt == 0) m_locked = 1'b1;
      if (m_locked) begin
        prod = longint'(sig) * longint'(sn);
        if (cnt == 0) m_sum = prod;
        else          m_sum = m_sum + prod;
        if (cnt == N - 1) begin
          m_pend     = 1'b1;
          m_pend_bit = (m_sum >= 0);
        end
      end
    end
    check("bit_valid", bit_valid, exp_bv);
    check("data_valid", data_valid, exp_dv);
    check("locked", locked, m_locked);
    check("data", data, m_data);
    if (exp_bv) check("bit_out", bit_out, exp_bit);
    if (bit_valid) begin
      bv_cnt++;
      obs_bits.push_back(bit_out);
    end
    if (data_valid) begin
      dv_cnt++;
      last_data = data;
    end
  endtask

  task automatic gap_step();
    step(1'b0, rnd_sample(), rnd_sample(), int'($urandom_range(N - 1)));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b1;
    signal_in = 12'h7FF;
    sine_in   = 12'h7FF;
    cnt_in    = 8'd255;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rst_bit_out", bit_out, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_data", data, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_locked", locked, 0);
  endtask

  // mode: 0 +sine, 1 -sine, 2 zero, 3 full-scale negative both, 4 random both
  // gap:  0 none, 1 en toggles every cycle, 2 random pauses
  task automatic send_period(input int mode, input int gap);
    int sig;
    int sn;
    for (int k = 0; k < N; k++) begin
      sn = rom[k];
      case (mode)
        0:       sig = rom[k];
        1:       sig = -rom[k];
        2:       sig = 0;
        3:       begin sig = -2048; sn = -2048; end
        default: begin sig = rnd_sample(); sn = rnd_sample(); end
      endcase
      step(1'b1, sig, sn, k);
      if (gap == 1) gap_step();
      else if (gap == 2 && $urandom_range(3) == 0) gap_step();
    end
  endtask

  task automatic flush();
    step(1'b1, 0, 0, 0);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap);
    for (int b = 0; b < DW; b++) send_period(w[b] ? 0 : 1, gap);
    flush();
  endtask

  initial begin
    int base;
    logic [DW-1:0] tx;
    logic [DW-1:0] w;

    for (int k = 0; k < N; k++) rom[k] = int'(2047.0 * $sin(2.0 * 3.14159265358979 * k / N));
    rst       = 1'b1;
    en        = 1'b0;
    signal_in = '0;
    sine_in   = '0;
    cnt_in    = '0;
    model_reset();
    do_reset();
    do_reset();

    // acquisition: stream starts mid-period
    for (int k = 100; k < N; k++) step(1'b1, rom[k], rom[k], k);
    check("acq_locked", locked, 0);
    check("acq_no_bits", bv_cnt, 0);

    // ideal symbols, zero signal, full-scale extremes
    send_period(0, 0);
    check("lock_after_wrap", locked, 1);
    check("first_bit_not_yet", bv_cnt, 0);
    send_period(1, 0);
    check("bits_after_p1", bv_cnt, 1);
    check("ideal_one", obs_bits[0], 1);
    send_period(2, 0);
    check("ideal_zero", obs_bits[1], 0);
    send_period(3, 0);
    check("zero_signal", obs_bits[2], 1);
    flush();
    check("full_scale", obs_bits[3], 1);
    check("bits_total", bv_cnt, 4);
    check("no_word_yet", dv_cnt, 0);

    // reset mid-word after bit 5
    do_reset();
    tx   = 12'hA5C;
    base = bv_cnt;
    for (int b = 0; b < 6; b++) send_period(tx[b] ? 0 : 1, 0);
    flush();
    check("partial_bits", bv_cnt - base, 6);
    do_reset();

    // loopback: two consecutive words
    base = dv_cnt;
    send_word(12'hA5C, 0);
    check("loop_word1", last_data, 12'hA5C);
    send_word(12'hA5C, 0);
    check("loop_words", dv_cnt - base, 2);
    check("loop_word2", last_data, 12'hA5C);

    // en gaps give the same word as a continuous run
    w = DW'($urandom);
    send_word(w, 0);
    check("cont_word", last_data, w);
    base = dv_cnt;
    send_word(w, 1);
    check("gap_word", last_data, w);
    check("gap_word_cnt", dv_cnt - base, 1);

    // random periods with random pauses
    for (int p = 0; p < 24; p++) send_period(4, 2);
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
